// File: rtl/stage4_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage4_mem_pkg
// Description : Shared bus widths and field offsets for the pipeline stage
//               buses (execute->memory, memory->write-back, memory->decode).
//               Imported by execute, decode, memory and write-back stages.
// Revision    : 1.0 - initial release
// ============================================================================
package stage4_mem_pkg;

    localparam int WIDTH_ES_TO_MS_BUS = 71;
    localparam int WIDTH_MS_TO_WS_BUS = 70;
    localparam int WIDTH_MS_TO_DS_BUS = 38;

    // execute -> memory bus fields
    localparam int ES_PC_LSB           = 0;
    localparam int ES_GR_WE_BIT        = 32;
    localparam int ES_RES_FROM_MEM_BIT = 33;
    localparam int ES_DEST_LSB         = 34;
    localparam int ES_ALU_RESULT_LSB   = 39;

    // memory -> write-back bus fields
    localparam int MS_PC_LSB           = 0;
    localparam int MS_GR_WE_BIT        = 32;
    localparam int MS_DEST_LSB         = 33;
    localparam int MS_FINAL_RESULT_LSB = 38;

endpackage : stage4_mem_pkg
`default_nettype wire

// File: rtl/stage4_mem_rdata_hold.sv
`default_nettype none
// ============================================================================
// Module      : ms_rdata_hold
// Description : Holds the synchronous data-SRAM read data while a load is
//               stalled in the memory stage, so the result stays stable even
//               after the SRAM output moves on.
// Ports       : clk, reset (async, active-high)
//               i_capture   - valid load occupies the stage and cannot leave
//               i_release   - occupying instruction leaves this cycle
//               i_rdata     - raw SRAM read data
//               o_load_data - held data when captured, else raw read data
// Revision    : 1.0 - initial release
// ============================================================================
module ms_rdata_hold (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_capture,
    input  logic        i_release,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
);

    logic        r_hold_vld;
    logic [31:0] r_hold_data;

    // Only the first stall cycle is captured; later cycles keep that value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= 32'd0;
        end else if (i_release) begin
            r_hold_vld  <= 1'b0;
        end else if (i_capture && !r_hold_vld) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= i_rdata;
        end
    end

    assign o_load_data = r_hold_vld ? r_hold_data : i_rdata;

endmodule : ms_rdata_hold
`default_nettype wire

// File: rtl/stage4_mem.sv
`default_nettype none
// ============================================================================
// Module      : stage4_mem
// Description : Memory-access stage of the five-stage pipeline. Registers the
//               execute->memory bus, selects load data or ALU result, feeds
//               write-back and the decode forwarding bus.
// Config      : MS_RDATA_HOLD_EN - when defined, builds ms_rdata_hold to keep
//               load data stable across write-back stalls.
// Ports       : clk, reset (async, active-high)
//               ws_allow_in / ms_allow_in          - handshake
//               es_to_ms_valid / es_to_ms_bus      - from execute
//               data_sram_rdata                    - SRAM read data
//               ms_to_ws_valid / ms_to_ws_bus      - to write-back
//               ms_to_ds_bus                       - forwarding to decode
// Revision    : 1.0 - initial release
// ============================================================================
module stage4_mem
    import stage4_mem_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ws_allow_in,
    output logic                          ms_allow_in,
    input  logic                          es_to_ms_valid,
    output logic                          ms_to_ws_valid,
    input  logic [WIDTH_ES_TO_MS_BUS-1:0] es_to_ms_bus,
    input  logic [31:0]                   data_sram_rdata,
    output logic [WIDTH_MS_TO_WS_BUS-1:0] ms_to_ws_bus,
    output logic [WIDTH_MS_TO_DS_BUS-1:0] ms_to_ds_bus
);

    logic                          r_ms_valid;
    logic [WIDTH_ES_TO_MS_BUS-1:0] r_ms_bus;

    logic        w_ms_ready_go;
    logic [31:0] w_pc;
    logic        w_gr_we;
    logic        w_res_from_mem;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;

    assign w_ms_ready_go  = 1'b1;
    assign ms_allow_in    = !r_ms_valid || (w_ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allow_in) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    // Bus register is not cleared on idle cycles; ms_valid qualifies it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_bus <= '0;
        end else if (es_to_ms_valid && ms_allow_in) begin
            r_ms_bus <= es_to_ms_bus;
        end
    end

    assign w_pc           = r_ms_bus[ES_PC_LSB +: 32];
    assign w_gr_we        = r_ms_bus[ES_GR_WE_BIT];
    assign w_res_from_mem = r_ms_bus[ES_RES_FROM_MEM_BIT];
    assign w_dest         = r_ms_bus[ES_DEST_LSB +: 5];
    assign w_alu_result   = r_ms_bus[ES_ALU_RESULT_LSB +: 32];

`ifdef MS_RDATA_HOLD_EN
    logic w_hold_capture;
    logic w_hold_release;

    assign w_hold_capture = r_ms_valid && w_res_from_mem && !ws_allow_in;
    assign w_hold_release = ms_to_ws_valid && ws_allow_in;

    ms_rdata_hold u_rdata_hold (
        .clk         (clk),
        .reset       (reset),
        .i_capture   (w_hold_capture),
        .i_release   (w_hold_release),
        .i_rdata     (data_sram_rdata),
        .o_load_data (w_load_data)
    );
`else
    // Without the hold register, write-back must never stall a load here.
    assign w_load_data = data_sram_rdata;
`endif

    assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;

    assign ms_to_ws_bus = {w_final_result, w_dest, w_gr_we, w_pc};
    assign ms_to_ds_bus = {r_ms_valid && w_gr_we, w_dest, w_final_result};

endmodule : stage4_mem
`default_nettype wire

// File: tb/tb_stage4_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage4_mem
// Description : Self-checking bench for stage4_mem: directed scenarios plus
//               randomized traffic against a behavioural occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage4_mem;

    logic        clk;
    logic        reset;
    logic        ws_allow_in;
    logic        ms_allow_in;
    logic        es_to_ms_valid;
    logic        ms_to_ws_valid;
    logic [70:0] es_to_ms_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] ms_to_ws_bus;
    logic [37:0] ms_to_ds_bus;

    int n_tests;
    int n_fail;

    // Model of the instruction currently held in the stage.
    bit          m_valid;
    logic [31:0] m_pc;
    logic        m_gr_we;
    logic        m_rfm;
    logic [4:0]  m_dest;
    logic [31:0] m_alu;
    bit          m_held;       // a stalled load has latched its data
    logic [31:0] m_held_data;

`ifdef MS_RDATA_HOLD_EN
    localparam bit c_HOLD = 1'b1;
`else
    localparam bit c_HOLD = 1'b0;
`endif

    stage4_mem u_dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allow_in     (ws_allow_in),
        .ms_allow_in     (ms_allow_in),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_to_ds_bus    (ms_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [70:0] mk_bus(input logic [31:0] pc, input logic gr_we,
                                           input logic rfm, input logic [4:0] dest,
                                           input logic [31:0] alu);
        return {alu, dest, rfm, gr_we, pc};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_gr_we = 0; m_rfm = 0; m_dest = 0; m_alu = 0;
        m_held = 0; m_held_data = 0;
    endtask

    // Compare all outputs against the model for the current inputs.
    task automatic check_outputs(input string tag);
        logic [31:0] load, fin;
        load = (c_HOLD && m_held) ? m_held_data : data_sram_rdata;
        fin  = m_rfm ? load : m_alu;
        check({tag, ".allow_in"}, 128'(ms_allow_in), 128'(!m_valid || ws_allow_in));
        check({tag, ".ws_valid"}, 128'(ms_to_ws_valid), 128'(m_valid));
        check({tag, ".ws_bus"}, 128'(ms_to_ws_bus), 128'({fin, m_dest, m_gr_we, m_pc}));
        check({tag, ".ds_bus"}, 128'(ms_to_ds_bus), 128'({m_valid && m_gr_we, m_dest, fin}));
    endtask

    // One cycle: drive inputs, check mid-cycle, advance model at the edge.
    task automatic step(input string tag, input logic ws, input logic esv,
                        input logic [70:0] bus, input logic [31:0] rdata);
        bit accept, leave;
        ws_allow_in     = ws;
        es_to_ms_valid  = esv;
        es_to_ms_bus    = bus;
        data_sram_rdata = rdata;
        #3;
        check_outputs(tag);
        accept = (!m_valid || ws) && esv;
        leave  = m_valid && ws;
        if (leave) m_held = 0;
        else if (m_valid && m_rfm && !m_held) begin
            m_held = 1;
            m_held_data = rdata;
        end
        if (!m_valid || ws) m_valid = esv;
        if (accept) begin
            m_pc = bus[31:0]; m_gr_we = bus[32]; m_rfm = bus[33];
            m_dest = bus[38:34]; m_alu = bus[70:39];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [70:0] rb;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        ws_allow_in = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; data_sram_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_state");
        reset = 1'b0;

        // Back-to-back ALU ops, no stalls.
        step("alu0", 1, 1, mk_bus(32'h100, 1, 0, 5'd1, 32'h11), 32'h0);
        step("alu1", 1, 1, mk_bus(32'h104, 1, 0, 5'd2, 32'h22), 32'h0);
        step("alu2", 1, 1, mk_bus(32'h108, 1, 0, 5'd3, 32'h33), 32'h0);
        check("alu_fwd_we", 128'(ms_to_ds_bus[37]), 128'(1'b1));
        check("alu_result_33", 128'(ms_to_ws_bus[69:38]), 128'(32'h33));

        // Load stalled 3 cycles, SRAM data changes during the stall.
        step("ld_in", 1, 1, mk_bus(32'h200, 1, 1, 5'd4, 32'h0), 32'h0);
        step("ld_st1", 0, 0, '0, 32'hDEADBEEF);
        step("ld_st2", 0, 1, mk_bus(32'h999, 1, 0, 5'd9, 32'h999), 32'h0);
        step("ld_st3", 0, 1, mk_bus(32'h999, 1, 0, 5'd9, 32'h999), 32'h0);
        if (c_HOLD) check("ld_hold_val", 128'(ms_to_ws_bus[69:38]), 128'(32'hDEADBEEF));
        // Release while a new ALU op enters on the same edge.
        step("ld_rel", 1, 1, mk_bus(32'h204, 1, 0, 5'd5, 32'h5), 32'h0);
        check("after_ld_alu5", 128'(ms_to_ws_bus[69:38]), 128'(32'h5));

        // Store op: no register write.
        step("st_in", 1, 1, mk_bus(32'h300, 0, 0, 5'd6, 32'h77), 32'h0);
        check("store_fwd_we", 128'(ms_to_ds_bus[37]), 128'(1'b0));
        check("store_gr_we", 128'(ms_to_ws_bus[32]), 128'(1'b0));
        step("idle", 1, 0, '0, 32'h0);

        // Asynchronous reset in the middle of a stalled load.
        step("rs_in", 1, 1, mk_bus(32'h400, 1, 1, 5'd7, 32'h0), 32'h1234);
        ws_allow_in = 1'b0; es_to_ms_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_ws_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        check("rst_ds_bus", 128'(ms_to_ds_bus), 128'(38'd0));
        check("rst_ws_bus", 128'(ms_to_ws_bus), 128'(70'd0));
        @(posedge clk);
        #4;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst0", 1, 1, mk_bus(32'h500, 1, 0, 5'd8, 32'hABC), 32'h0);
        check("post_rst_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        step("post_rst1", 1, 0, '0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rb = {$urandom(), 5'($urandom()), 2'($urandom()), $urandom()};
            step("rand", ($urandom_range(0, 3) != 0), 1'($urandom()), rb, $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_stage4_mem
`default_nettype wire

// File: doc/stage4_mem.md
# stage4_mem

Memory-access stage of the five-stage in-order pipeline, between the execute stage and the write-back stage. It registers the execute-to-memory bus, selects the load return data or the ALU result as the final result, and presents it to write-back. It also drives the forwarding bus back to decode. A holding register keeps the synchronous data-SRAM read data stable while write-back stalls.

## Interface
Parameters: none. Bus widths are shared constants: WIDTH_ES_TO_MS_BUS = 71, WIDTH_MS_TO_WS_BUS = 70, WIDTH_MS_TO_DS_BUS = 38.

- clk  in  1  sole clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ws_allow_in  in  1  write-back can accept an instruction this cycle
- ms_allow_in  out  1  this stage can accept an instruction this cycle
- es_to_ms_valid  in  1  execute presents a valid instruction
- ms_to_ws_valid  out  1  this stage presents a valid instruction
- es_to_ms_bus  in  71  [31:0] pc, [32] gr_we, [33] res_from_mem, [38:34] dest, [70:39] alu_result
- data_sram_rdata  in  32  synchronous SRAM read data for the address issued by execute one cycle earlier
- ms_to_ws_bus  out  70  [31:0] pc, [32] gr_we, [37:33] dest, [69:38] final_result
- ms_to_ds_bus  out  38  {fwd_we, dest[4:0], final_result[31:0]}; fwd_we = ms_valid & gr_we

## Operation
- ms_valid register:
  - on reset: 0
  - else if ms_allow_in: ms_valid ← es_to_ms_valid
- Bus register:
  - on reset: 0
  - loads es_to_ms_bus when es_to_ms_valid & ms_allow_in
  - otherwise holds; it is never cleared on idle cycles
- Handshake:
  - ms_ready_go = 1
  - ms_allow_in = !ms_valid | (ms_ready_go & ws_allow_in)
  - ms_to_ws_valid = ms_valid & ms_ready_go
- Read-data hold:
  - hold_vld flag and 32-bit hold_data register
  - on the first cycle a valid load (res_from_mem = 1) occupies the stage and does not leave (ws_allow_in = 0): hold_data ← data_sram_rdata, hold_vld ← 1
  - hold_vld clears when the instruction leaves (ms_to_ws_valid & ws_allow_in) or on reset
  - a new instruction entering in the same cycle the old one leaves starts with hold_vld = 0
- load_data = hold_vld ? hold_data : data_sram_rdata
- final_result = res_from_mem ? load_data : alu_result; full 32-bit word, no sign or byte extraction
- ms_to_ds_bus is driven combinationally from current registers; fwd_we = 0 whenever ms_valid = 0

## Timing
- Latency: 1 cycle from acceptance (es_to_ms_valid & ms_allow_in at edge N) to ms_to_ws_valid high in cycle N+1.
- Throughput: 1 instruction per cycle when ws_allow_in stays high.
- Outputs after reset:
  - ms_to_ws_valid = 0, ms_allow_in = 1
  - ms_to_ws_bus = 0, ms_to_ds_bus = 0
- Stall:
  - while ws_allow_in = 0 and ms_valid = 1, all outputs stay constant
  - this holds even if data_sram_rdata changes after the first cycle
- Reset asserted mid-stall drops the instruction; there is no replay.

## Configuration
- MS_RDATA_HOLD_EN defined: hold_vld/hold_data are built as described above.
- Undefined: no hold logic; load_data = data_sram_rdata directly. This is correct only if write-back never deasserts ws_allow_in while a load occupies the stage.

## Structure
- The shared package holds the WIDTH_* bus constants and the bit-offset constants for each bus field. It is shared with the execute, decode and write-back stages.
- One sub-module, ms_rdata_hold (flag plus data register plus mux), is instantiated under MS_RDATA_HOLD_EN.

## Test plan
- Reset pulse mid-run → ms_to_ws_valid = 0, ms_to_ds_bus = 0 immediately (asynchronous); first accepted instruction appears 1 cycle after reset release.
- Back-to-back ALU ops (alu_result 0x11, 0x22, 0x33), ws_allow_in = 1 → final_result 0x11, 0x22, 0x33 on consecutive cycles; fwd_we = 1 each cycle.
- Load with rdata = 0xDEADBEEF, ws_allow_in low for 3 cycles, rdata changed to 0x0 in cycle 2 → final_result stays 0xDEADBEEF for all stall cycles and on release.
- Load leaves and a new ALU op (0x5) enters the same edge → next cycle final_result = 0x5, hold flag cleared.
- gr_we = 0 store op → fwd_we = 0, ms_to_ws_bus[32] = 0.
- es_to_ms_valid = 1 while stalled (ms_allow_in = 0) → bus register unchanged, incoming instruction not accepted.
